// File: rtl/fpgame_vram_pkg.sv
// Shared types and default geometry for the HPS-to-VRAM write buffer.
package fpgame_vram_pkg;

  localparam int DEF_NUM_VRAM = 4;
  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_SEL_W    = (DEF_NUM_VRAM > 1) ? $clog2(DEF_NUM_VRAM) : 1;

  // Queue entry layout for the default geometry; the FIFO keys on {sel, addr}.
  typedef struct packed {
    logic [DEF_SEL_W-1:0]    sel;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_DATA_W/8-1:0] be;
  } vram_wr_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } vram_wr_state_e;

  function automatic int sel_width(input int num_vram);
    return (num_vram > 1) ? $clog2(num_vram) : 1;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO of {key, data, be} entries; with MERGE_EN a push matching the
// tail key is folded into the tail entry instead of allocating a new slot.
module vram_wr_fifo
  import fpgame_vram_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int KEY_W    = DEF_SEL_W + DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter bit MERGE_EN = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic [KEY_W-1:0]    i_push_key,
  input  logic [DATA_W-1:0]   i_push_data,
  input  logic [DATA_W/8-1:0] i_push_be,
  input  logic                i_pop,
  output logic [KEY_W-1:0]    o_head_key,
  output logic [DATA_W-1:0]   o_head_data,
  output logic [DATA_W/8-1:0] o_head_be,
  output logic                o_empty,
  output logic                o_empty_next,
  output logic                o_busy,
  output logic                o_drop,
  output logic                o_pop
);

  localparam int BE_W = DATA_W / 8;
  localparam int AW   = $clog2(DEPTH);

  logic [KEY_W-1:0]  r_key  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [BE_W-1:0]   r_be   [DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic              r_busy;

  logic [AW:0]       w_wr_next, w_rd_next, w_count;
  logic [AW-1:0]     w_tail;
  logic              w_full, w_pop, w_merge, w_alloc;
  logic [DATA_W-1:0] w_merge_data;

  always_comb begin
    w_count      = r_wr_ptr - r_rd_ptr;
    w_tail       = r_wr_ptr[AW-1:0] - AW'(1);
    w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    o_empty      = (r_wr_ptr == r_rd_ptr);
    w_pop        = i_pop && !o_empty;
    // The tail may not be merged into while it is the entry leaving this cycle.
    w_merge      = MERGE_EN && i_push && !o_empty && (r_key[w_tail] == i_push_key)
                   && !(w_pop && (w_count == (AW+1)'(1)));
    w_alloc      = i_push && !w_merge && (!w_full || w_pop);
    o_drop       = i_push && !w_merge && w_full && !w_pop;
    w_wr_next    = r_wr_ptr + (AW+1)'(w_alloc);
    w_rd_next    = r_rd_ptr + (AW+1)'(w_pop);
    o_empty_next = (w_wr_next == w_rd_next);
    w_merge_data = r_data[w_tail];
    for (int b = 0; b < BE_W; b++) begin
      if (i_push_be[b]) w_merge_data[b*8 +: 8] = i_push_data[b*8 +: 8];
      else              w_merge_data[b*8 +: 8] = r_data[w_tail][b*8 +: 8];
    end
  end

  assign o_head_key  = r_key[r_rd_ptr[AW-1:0]];
  assign o_head_data = r_data[r_rd_ptr[AW-1:0]];
  assign o_head_be   = r_be[r_rd_ptr[AW-1:0]];
  assign o_busy      = r_busy;
  assign o_pop       = w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_busy   <= (w_wr_next[AW] != w_rd_next[AW]) && (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_alloc) begin
      r_key[r_wr_ptr[AW-1:0]]  <= i_push_key;
      r_data[r_wr_ptr[AW-1:0]] <= i_push_data;
      r_be[r_wr_ptr[AW-1:0]]   <= i_push_be;
    end else if (!reset && w_merge) begin
      r_data[w_tail] <= w_merge_data;
      r_be[w_tail]   <= r_be[w_tail] | i_push_be;
    end
  end

endmodule

// File: rtl/h2f_vram_wr_buffer.sv
// HPS-to-VRAM write buffer: queues CPU writes and drains them during the PPU write window.
// Define H2F_VRAM_COALESCE_EN to merge writes that hit the same {sel, addr} as the tail.
module h2f_vram_wr_buffer
  import fpgame_vram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_VRAM = DEF_NUM_VRAM,
  parameter int DEPTH    = DEF_DEPTH,
  localparam int BE_W    = DATA_W / 8,
  localparam int SEL_W   = sel_width(NUM_VRAM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SEL_W+ADDR_W-1:0]    cpu_wraddr,
  input  logic                       cpu_wren,
  input  logic [DATA_W-1:0]          cpu_wrdata,
  input  logic [BE_W-1:0]            cpu_byteena,
  input  logic                       vram_wr_window,
  output logic [NUM_VRAM*ADDR_W-1:0] vram_wraddr,
  output logic [NUM_VRAM-1:0]        vram_wren,
  output logic [NUM_VRAM*DATA_W-1:0] vram_wrdata,
  output logic [NUM_VRAM*BE_W-1:0]   vram_byteena,
  output logic                       cpu_wr_busy,
  output logic                       cpu_wr_overflow,
  output logic                       cpu_vram_wr_irq
);

  localparam int KEY_W = SEL_W + ADDR_W;
`ifdef H2F_VRAM_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  vram_wr_state_e            r_state;
  logic [NUM_VRAM-1:0]        r_vram_wren;
  logic [NUM_VRAM*ADDR_W-1:0] r_vram_wraddr;
  logic [NUM_VRAM*DATA_W-1:0] r_vram_wrdata;
  logic [NUM_VRAM*BE_W-1:0]   r_vram_byteena;
  logic                       r_overflow, r_irq;

  logic [SEL_W-1:0]  w_sel, w_head_sel;
  logic [KEY_W-1:0]  w_head_key;
  logic [DATA_W-1:0] w_head_data;
  logic [BE_W-1:0]   w_head_be;
  logic              w_push, w_pop_req, w_pop, w_empty, w_empty_next, w_busy, w_drop;

  // Out-of-range selects and empty byte masks never reach the queue; the reset cycle accepts nothing.
  assign w_sel      = cpu_wraddr[KEY_W-1 -: SEL_W];
  assign w_push     = cpu_wren && !reset && (int'(w_sel) < NUM_VRAM) && (cpu_byteena != '0);
  assign w_pop_req  = (r_state == ST_DRAIN) && vram_wr_window;
  assign w_head_sel = w_head_key[KEY_W-1 -: SEL_W];

  vram_wr_fifo #(
    .DEPTH    (DEPTH),
    .KEY_W    (KEY_W),
    .DATA_W   (DATA_W),
    .MERGE_EN (COALESCE)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_key   (cpu_wraddr),
    .i_push_data  (cpu_wrdata),
    .i_push_be    (cpu_byteena),
    .i_pop        (w_pop_req),
    .o_head_key   (w_head_key),
    .o_head_data  (w_head_data),
    .o_head_be    (w_head_be),
    .o_empty      (w_empty),
    .o_empty_next (w_empty_next),
    .o_busy       (w_busy),
    .o_drop       (w_drop),
    .o_pop        (w_pop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_vram_wren    <= '0;
      r_vram_wraddr  <= '0;
      r_vram_wrdata  <= '0;
      r_vram_byteena <= '0;
      r_overflow     <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      // Non-selected targets keep wren low and hold their last address/data/byteena.
      for (int t = 0; t < NUM_VRAM; t++) begin
        r_vram_wren[t] <= w_pop && (w_head_sel == SEL_W'(t));
        if (w_pop && (w_head_sel == SEL_W'(t))) begin
          r_vram_wraddr[t*ADDR_W +: ADDR_W] <= w_head_key[ADDR_W-1:0];
          r_vram_wrdata[t*DATA_W +: DATA_W] <= w_head_data;
          r_vram_byteena[t*BE_W +: BE_W]    <= w_head_be;
        end
      end
      case (r_state)
        ST_IDLE:  if (vram_wr_window && !w_empty) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!vram_wr_window)             r_state <= ST_IDLE;
          else if (w_empty || w_empty_next) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_irq   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign vram_wren       = r_vram_wren;
  assign vram_wraddr     = r_vram_wraddr;
  assign vram_wrdata     = r_vram_wrdata;
  assign vram_byteena    = r_vram_byteena;
  assign cpu_wr_busy     = w_busy;
  assign cpu_wr_overflow = r_overflow;
  assign cpu_vram_wr_irq = r_irq;

endmodule

// File: tb/tb_h2f_vram_wr_buffer.sv
// Directed bench for h2f_vram_wr_buffer (4 targets, depth 16) plus a 3-target instance
// for out-of-range select handling.
module tb_h2f_vram_wr_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] cpu_wraddr;
  logic        cpu_wren;
  logic [63:0] cpu_wrdata;
  logic [7:0]  cpu_byteena;
  logic        vram_wr_window;
  logic [51:0] vram_wraddr;
  logic [3:0]  vram_wren;
  logic [255:0] vram_wrdata;
  logic [31:0] vram_byteena;
  logic        cpu_wr_busy, cpu_wr_overflow, cpu_vram_wr_irq;

  logic        u3_wren_in, u3_window;
  logic [38:0] u3_wraddr;
  logic [2:0]  u3_wren;
  logic [191:0] u3_wrdata;
  logic [23:0] u3_byteena;
  logic        u3_busy, u3_overflow, u3_irq;

  int n_cmp = 0, n_fail = 0;
  int total_wr = 0, irq_cnt = 0, onehot_err = 0;
  int wr0, irq0;

  always #5 clk = ~clk;

  h2f_vram_wr_buffer dut (
    .clk(clk), .reset(reset), .cpu_wraddr(cpu_wraddr), .cpu_wren(cpu_wren),
    .cpu_wrdata(cpu_wrdata), .cpu_byteena(cpu_byteena), .vram_wr_window(vram_wr_window),
    .vram_wraddr(vram_wraddr), .vram_wren(vram_wren), .vram_wrdata(vram_wrdata),
    .vram_byteena(vram_byteena), .cpu_wr_busy(cpu_wr_busy),
    .cpu_wr_overflow(cpu_wr_overflow), .cpu_vram_wr_irq(cpu_vram_wr_irq)
  );

  h2f_vram_wr_buffer #(.NUM_VRAM(3), .DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .cpu_wraddr(cpu_wraddr), .cpu_wren(u3_wren_in),
    .cpu_wrdata(cpu_wrdata), .cpu_byteena(cpu_byteena), .vram_wr_window(u3_window),
    .vram_wraddr(u3_wraddr), .vram_wren(u3_wren), .vram_wrdata(u3_wrdata),
    .vram_byteena(u3_byteena), .cpu_wr_busy(u3_busy),
    .cpu_wr_overflow(u3_overflow), .cpu_vram_wr_irq(u3_irq)
  );

  // Scoreboard of issued writes and irq pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      total_wr += $countones(vram_wren);
      irq_cnt  += int'(cpu_vram_wr_irq);
      if ($countones(vram_wren) > 1) onehot_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic [12:0] addr,
                      input logic [63:0] data, input logic [7:0] be);
    cpu_wraddr  = {sel, addr};
    cpu_wrdata  = data;
    cpu_byteena = be;
    cpu_wren    = 1'b1;
    tick();
    cpu_wren    = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int max_cycles);
    logic got = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      tick();
      if (cpu_vram_wr_irq) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, 64'(got), 64'd1);
  endtask

  function automatic logic [12:0] taddr(input int t);
    return vram_wraddr[t*13 +: 13];
  endfunction

  function automatic logic [63:0] tdata(input int t);
    return vram_wrdata[t*64 +: 64];
  endfunction

  function automatic logic [7:0] tbe(input int t);
    return vram_byteena[t*8 +: 8];
  endfunction

  initial begin
    reset = 1'b1; cpu_wren = 1'b0; cpu_wraddr = '0; cpu_wrdata = '0; cpu_byteena = '0;
    vram_wr_window = 1'b0; u3_wren_in = 1'b0; u3_window = 1'b0;
    tick(); tick();
    check("rst_wren", 64'(vram_wren), 64'd0);
    check("rst_busy", 64'(cpu_wr_busy), 64'd0);
    check("rst_ovf", 64'(cpu_wr_overflow), 64'd0);
    check("rst_irq", 64'(cpu_vram_wr_irq), 64'd0);
    check("rst_addr0", 64'(taddr(0)), 64'd0);
    reset = 1'b0;

    // Three targets queued with the window closed, then drained back to back.
    push(2'd0, 13'h001, 64'hD0D0_0000_0000_0001, 8'hFF);
    push(2'd1, 13'h002, 64'hD1D1_0000_0000_0002, 8'h3C);
    push(2'd3, 13'h003, 64'hD3D3_0000_0000_0003, 8'hFF);
    tick();
    check("t1_hold", 64'(vram_wren), 64'd0);
    vram_wr_window = 1'b1;
    tick();
    check("t1_enter", 64'(vram_wren), 64'd0);
    tick();
    check("t1_w0", 64'(vram_wren), 64'b0001);
    check("t1_a0", 64'(taddr(0)), 64'h001);
    check("t1_d0", tdata(0), 64'hD0D0_0000_0000_0001);
    tick();
    check("t1_w1", 64'(vram_wren), 64'b0010);
    check("t1_be1", 64'(tbe(1)), 64'h3C);
    tick();
    check("t1_w3", 64'(vram_wren), 64'b1000);
    check("t1_d3", tdata(3), 64'hD3D3_0000_0000_0003);
    check("t1_a0_hold", 64'(taddr(0)), 64'h001);
    tick();
    check("t1_irq", 64'(cpu_vram_wr_irq), 64'd1);
    check("t1_irq_wren", 64'(vram_wren), 64'd0);
    tick();
    check("t1_irq_drop", 64'(cpu_vram_wr_irq), 64'd0);
    vram_wr_window = 1'b0;

    // Fill to 16, drop the 17th, then drain exactly 16.
    for (int i = 0; i < 16; i++) begin
      push(2'(i % 4), 13'(32'h100 + i), 64'(i), 8'hFF);
      if (i == 14) check("t2_busy_15", 64'(cpu_wr_busy), 64'd0);
    end
    check("t2_busy_16", 64'(cpu_wr_busy), 64'd1);
    push(2'd1, 13'h1FF, 64'hDEAD, 8'h00);
    check("t2_be0_full_ovf", 64'(cpu_wr_overflow), 64'd0);
    push(2'd2, 13'h1FE, 64'hBEEF, 8'hFF);
    check("t2_ovf", 64'(cpu_wr_overflow), 64'd1);
    check("t2_busy_17", 64'(cpu_wr_busy), 64'd1);
    wr0 = total_wr;
    vram_wr_window = 1'b1;
    wait_irq("t2_irq", 40);
    check("t2_count", 64'(total_wr - wr0), 64'd16);
    check("t2_busy_end", 64'(cpu_wr_busy), 64'd0);
    check("t2_ovf_sticky", 64'(cpu_wr_overflow), 64'd1);
    check("t2_last_a3", 64'(taddr(3)), 64'h10F);
    check("t2_last_d2", tdata(2), 64'd14);
    tick();
    vram_wr_window = 1'b0;

    // Reset mid-drain with a write presented during reset.
    for (int i = 0; i < 6; i++) push(2'(i % 4), 13'(32'h0A0 + i), 64'(32'hA0 + i), 8'hFF);
    vram_wr_window = 1'b1;
    tick(); tick(); tick();
    check("r_pre_wren", 64'(vram_wren), 64'b0010);
    reset = 1'b1;
    cpu_wraddr = {2'd0, 13'h0AA}; cpu_wrdata = 64'd1; cpu_byteena = 8'hFF; cpu_wren = 1'b1;
    tick();
    cpu_wren = 1'b0;
    tick();
    reset = 1'b0;
    check("r_busy", 64'(cpu_wr_busy), 64'd0);
    check("r_ovf_clr", 64'(cpu_wr_overflow), 64'd0);
    check("r_wren", 64'(vram_wren), 64'd0);
    wr0 = total_wr; irq0 = irq_cnt;
    repeat (6) tick();
    check("r_no_wr", 64'(total_wr - wr0), 64'd0);
    check("r_no_irq", 64'(irq_cnt - irq0), 64'd0);
    vram_wr_window = 1'b0;

    // Window closes after two pops; remainder drains on reopening.
    for (int i = 0; i < 5; i++) push(2'(i % 4), 13'(32'h400 + i), 64'(32'h400 + i), 8'hFF);
    wr0 = total_wr; irq0 = irq_cnt;
    vram_wr_window = 1'b1;
    tick(); tick(); tick();
    vram_wr_window = 1'b0;
    repeat (4) tick();
    check("t3_partial", 64'(total_wr - wr0), 64'd2);
    check("t3_no_irq", 64'(irq_cnt - irq0), 64'd0);
    vram_wr_window = 1'b1;
    wait_irq("t3_irq", 30);
    check("t3_total", 64'(total_wr - wr0), 64'd5);
    check("t3_last_a0", 64'(taddr(0)), 64'h404);
    tick();
    check("t3_irq_drop", 64'(cpu_vram_wr_irq), 64'd0);
    vram_wr_window = 1'b0;

    // Discarded pushes: empty byte mask here, out-of-range select on the 3-target instance.
    push(2'd0, 13'h050, 64'h55, 8'h00);
    check("t4_be0_busy", 64'(cpu_wr_busy), 64'd0);
    check("t4_be0_ovf", 64'(cpu_wr_overflow), 64'd0);
    wr0 = total_wr; irq0 = irq_cnt;
    vram_wr_window = 1'b1;
    repeat (4) tick();
    check("t4_be0_no_wr", 64'(total_wr - wr0), 64'd0);
    check("t4_be0_no_irq", 64'(irq_cnt - irq0), 64'd0);
    vram_wr_window = 1'b0;
    cpu_wraddr = {2'd3, 13'h005}; cpu_wrdata = 64'h33; cpu_byteena = 8'hFF;
    u3_wren_in = 1'b1;
    tick();
    u3_wren_in = 1'b0;
    check("t4_sel3_busy", 64'(u3_busy), 64'd0);
    u3_window = 1'b1;
    repeat (4) tick();
    check("t4_sel3_wren", 64'(u3_wren), 64'd0);
    check("t4_sel3_ovf", 64'(u3_overflow), 64'd0);
    check("t4_sel3_irq", 64'(u3_irq), 64'd0);
    cpu_wraddr = {2'd2, 13'h007}; cpu_wrdata = 64'h77;
    u3_wren_in = 1'b1;
    tick();
    u3_wren_in = 1'b0;
    check("t4_nobypass0", 64'(u3_wren), 64'd0);
    tick();
    check("t4_nobypass1", 64'(u3_wren), 64'd0);
    tick();
    check("t4_u3_wren", 64'(u3_wren), 64'b100);
    check("t4_u3_addr", 64'(u3_wraddr[26 +: 13]), 64'h007);
    tick();
    check("t4_u3_irq", 64'(u3_irq), 64'd1);
    u3_window = 1'b0;

    // Full FIFO with the window open: push every cycle, writes never gap.
    for (int i = 0; i < 16; i++) push(2'(i % 4), 13'(32'h200 + i), 64'(i), 8'hFF);
    check("t5_full", 64'(cpu_wr_busy), 64'd1);
    wr0 = total_wr;
    vram_wr_window = 1'b1;
    tick();
    check("t5_enter", 64'(vram_wren), 64'd0);
    cpu_wren = 1'b1; cpu_byteena = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      cpu_wraddr = {2'(i % 4), 13'(32'h300 + i)};
      cpu_wrdata = 64'(32'h300 + i);
      tick();
      check("t5_cont_push", 64'($countones(vram_wren)), 64'd1);
    end
    cpu_wren = 1'b0;
    check("t5_busy", 64'(cpu_wr_busy), 64'd1);
    check("t5_ovf", 64'(cpu_wr_overflow), 64'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t5_cont_drain", 64'($countones(vram_wren)), 64'd1);
    end
    check("t5_last_a3", 64'(taddr(3)), 64'h313);
    tick();
    check("t5_irq", 64'(cpu_vram_wr_irq), 64'd1);
    check("t5_total", 64'(total_wr - wr0), 64'd36);
    tick();
    vram_wr_window = 1'b0;

    // Two writes to the same {sel, addr}: merged only in the coalescing build.
    push(2'd2, 13'h010, 64'h1111_2222_AAAA_BBBB, 8'h0F);
    push(2'd2, 13'h010, 64'hCCCC_DDDD_3333_4444, 8'hF0);
    wr0 = total_wr;
    vram_wr_window = 1'b1;
    wait_irq("t6_irq", 20);
`ifdef H2F_VRAM_COALESCE_EN
    check("t6_count", 64'(total_wr - wr0), 64'd1);
    check("t6_be", 64'(tbe(2)), 64'hFF);
    check("t6_data", tdata(2), 64'hCCCC_DDDD_AAAA_BBBB);
`else
    check("t6_count", 64'(total_wr - wr0), 64'd2);
    check("t6_be", 64'(tbe(2)), 64'hF0);
    check("t6_data", tdata(2), 64'hCCCC_DDDD_3333_4444);
`endif
    tick();
    vram_wr_window = 1'b0;
    check("onehot", 64'(onehot_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
